// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: MAC with valid/last framing, saturation,
// and a result register draining over a valid/ready column chain.
module systolic_pe_os #(
   parameter int DATAWIDTH = 16,
   parameter int ACCWIDTH  = 40,
   parameter int SIGNED    = 1,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic                 valid_in,
   input  logic                 last_in,
   output logic [DATAWIDTH-1:0] a_out,
   output logic [DATAWIDTH-1:0] b_out,
   output logic                 valid_out,
   output logic                 last_out,
   input  logic [ACCWIDTH-1:0]  res_in,
   input  logic                 res_valid_in,
   output logic                 res_ready_out,
   output logic [ACCWIDTH-1:0]  res_out,
   output logic                 res_valid_out,
   input  logic                 res_ready_in,
   output logic                 sat_flag,
   output logic                 ovr_err
);

   localparam int PW = 2 * DATAWIDTH;
   localparam int SW = ACCWIDTH + 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state;
   logic [PW-1:0]       a_x;
   logic [PW-1:0]       b_x;
   logic [PW-1:0]       prod;
   logic [SW-1:0]       prod_x;
   logic [SW-1:0]       acc_x;
   logic [SW-1:0]       sum;
   logic [ACCWIDTH-1:0] acc;
   logic [ACCWIDTH-1:0] acc_nxt;
   logic [ACCWIDTH-1:0] res_reg;
   logic                ovf;
   logic                sat_hit;
   logic                pending;
   logic                slot_free;
   logic                tile_end;

   // Operands extended to 2*DW so the low half of the product is exact
   always_comb begin
      a_x = '0;
      b_x = '0;
      if (SIGNED != 0) begin
         a_x = {{DATAWIDTH{a[DATAWIDTH-1]}}, a};
         b_x = {{DATAWIDTH{b[DATAWIDTH-1]}}, b};
      end else begin
         a_x = {{DATAWIDTH{1'b0}}, a};
         b_x = {{DATAWIDTH{1'b0}}, b};
      end
      prod = a_x * b_x;
   end

   always_comb begin
      prod_x  = '0;
      acc_x   = '0;
      ovf     = 1'b0;
      acc_nxt = '0;
      if (SIGNED != 0) begin
         prod_x = {{(SW-PW){prod[PW-1]}}, prod};
         acc_x  = {acc[ACCWIDTH-1], acc};
      end else begin
         prod_x = {{(SW-PW){1'b0}}, prod};
         acc_x  = {1'b0, acc};
      end
      sum = acc_x + prod_x;
      if (SIGNED != 0)
         ovf = sum[SW-1] != sum[SW-2];
      else
         ovf = sum[SW-1];
      sat_hit = (SATURATE != 0) && ovf;
      acc_nxt = sum[ACCWIDTH-1:0];
      if (sat_hit) begin
         if (SIGNED == 0)
            acc_nxt = '1;
         else if (sum[SW-1])
            acc_nxt = {1'b1, {(ACCWIDTH-1){1'b0}}};
         else
            acc_nxt = {1'b0, {(ACCWIDTH-1){1'b1}}};
      end
   end

   assign res_valid_out = (state == FULL);
   assign slot_free     = (state == EMPTY) || res_ready_in;
   assign res_ready_out = slot_free && !pending;
   assign tile_end      = valid_in && last_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out     <= '0;
         b_out     <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
         acc       <= '0;
         res_reg   <= '0;
         res_out   <= '0;
         pending   <= 1'b0;
         state     <= EMPTY;
         sat_flag  <= 1'b0;
         ovr_err   <= 1'b0;
      end else begin
         a_out     <= a;
         b_out     <= b;
         valid_out <= valid_in;
         last_out  <= last_in;
         if (valid_in) begin
            if (sat_hit)
               sat_flag <= 1'b1;
            if (last_in) begin
               acc <= '0;
               if (pending && !slot_free)
                  ovr_err <= 1'b1;
               else
                  res_reg <= acc_nxt;
            end else begin
               acc <= acc_nxt;
            end
         end
         // A tile end refills pending even while the old result drains
         pending <= tile_end || (pending && !slot_free);
         if (slot_free) begin
            if (pending) begin
               res_out <= res_reg;
               state   <= FULL;
            end else if (res_valid_in) begin
               res_out <= res_in;
               state   <= FULL;
            end else begin
               state <= EMPTY;
            end
         end
      end
   end

endmodule
